pzbcm_handshake_packer: RTL



---
 rtl/pzbcm_handshake_packer.sv | 92 +++++++++
 1 files changed

// File: rtl/pzbcm_handshake_packer.sv
// Packs up to ENTRIES narrow items into one wide packet ahead of a
// clock-domain-crossing handshake. A packet closes when full, after
// TIMEOUT idle-ish cycles, or on i_flush, and is offered on a registered
// valid/ready output.
module pzbcm_handshake_packer #(
  parameter int WIDTH       = 8,
  parameter int ENTRIES     = 4,
  parameter int TIMEOUT     = 16,
  parameter int COUNT_WIDTH = $clog2(ENTRIES + 1)
)(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [ENTRIES*WIDTH-1:0]   o_data,
  output logic [COUNT_WIDTH-1:0]     o_count
);

  localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [AGE_W-1:0]       AGE_MAX = AGE_W'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] FULL    = COUNT_WIDTH'(ENTRIES);

  logic [ENTRIES-1:0][WIDTH-1:0] slot;
  logic [ENTRIES-1:0][WIDTH-1:0] packed_slots;
  logic [COUNT_WIDTH-1:0]        fill_count;
  logic [AGE_W-1:0]              age;
  logic                          accept;
  logic                          timed_out;
  logic                          close_req;
  logic                          transfer;

  // o_ready depends on fill_count only, so i_ready/i_flush never reach it.
  assign o_ready   = (fill_count != FULL);
  assign accept    = i_valid && o_ready;
  assign timed_out = (TIMEOUT != 0) && (age == AGE_MAX);
  assign close_req = (fill_count != '0) &&
                     ((fill_count == FULL) || timed_out || i_flush);
  assign transfer  = close_req && (!o_valid || i_ready);

  // Slots beyond fill_count are forced to zero in the outgoing packet.
  always_comb begin
    packed_slots = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (COUNT_WIDTH'(k) < fill_count) packed_slots[k] = slot[k];
    end
  end

  // Fill buffer: an item accepted in a transfer cycle starts the next packet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot       <= '0;
      fill_count <= '0;
      age        <= '0;
    end else if (transfer) begin
      slot       <= '0;
      fill_count <= '0;
      age        <= '0;
      if (accept) begin
        slot[0]    <= i_data;
        fill_count <= COUNT_WIDTH'(1);
      end
    end else begin
      if (accept) begin
        slot[fill_count[IDX_W-1:0]] <= i_data;
        fill_count                  <= fill_count + COUNT_WIDTH'(1);
      end
      if (fill_count == '0)    age <= '0;
      else if (age != AGE_MAX) age <= age + AGE_W'(1);
    end
  end

  // Output register: loads on transfer, holds while stalled, drops after use.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
    end else if (transfer) begin
      o_valid <= 1'b1;
      o_data  <= packed_slots;
      o_count <= fill_count;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
